// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between requesters A and B.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise A has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic Clk,
    input  logic Rst_n,
    input  logic grant,
`endif
    input  logic req_a,
    input  logic req_b,
    output logic winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers the last granted port; resets to B so that A is preferred first.
    logic last_reg;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            last_reg <= PORT_B;
        end else if (grant) begin
            last_reg <= winner;
        end
    end

    always_comb begin
        winner = PORT_B;
        if (req_a && req_b) begin
            winner = (last_reg == PORT_A) ? PORT_B : PORT_A;
        end else if (req_a) begin
            winner = PORT_A;
        end
    end
`else
    assign winner = req_a ? PORT_A : PORT_B;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle data memory (IDLE -> ACCESS -> RESP).
// Optional MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqA,
    input  logic              WeA,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [DATA_W-1:0] WDataA,
    input  logic              ReqB,
    input  logic              WeB,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WDataB,
    output logic              GntA,
    output logic              GntB,
    output logic              RValidA,
    output logic              RValidB,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemReadData
);

    state_t            state_reg, state_next;
    logic              cmd_we_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [DATA_W-1:0] cmd_wdata_reg;
    logic              cmd_port_reg;
    logic              winner;
    logic              take;

    assign take = (state_reg == IDLE) && (ReqA || ReqB);

    mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .grant  (take),
`endif
        .req_a  (ReqA),
        .req_b  (ReqB),
        .winner (winner)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg     <= IDLE;
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            cmd_port_reg  <= PORT_A;
        end else begin
            state_reg <= state_next;
            if (take) begin
                cmd_port_reg  <= winner;
                cmd_we_reg    <= (winner == PORT_B) ? WeB    : WeA;
                cmd_addr_reg  <= (winner == PORT_B) ? AddrB  : AddrA;
                cmd_wdata_reg <= (winner == PORT_B) ? WDataB : WDataA;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (take) state_next = ACCESS;
            ACCESS:  state_next = cmd_we_reg ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The command register feeds the memory bus permanently; only the enables are gated.
    always_comb begin
        GntA         = 1'b0;
        GntB         = 1'b0;
        RValidA      = 1'b0;
        RValidB      = 1'b0;
        RData        = '0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemAddress   = cmd_addr_reg;
        MemWriteData = cmd_wdata_reg;
        case (state_reg)
            ACCESS: begin
                MemWrite = cmd_we_reg;
                MemRead  = !cmd_we_reg;
                GntA     = (cmd_port_reg == PORT_A);
                GntB     = (cmd_port_reg == PORT_B);
            end
            RESP: begin
                RData   = MemReadData;
                RValidA = (cmd_port_reg == PORT_A);
                RValidB = (cmd_port_reg == PORT_B);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus directed cases.
// Honours MEM_ARB_ROUND_ROBIN_EN to select the expected arbitration policy.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        ReqA, WeA, ReqB, WeB;
    logic [31:0] AddrA, WDataA, AddrB, WDataB;
    logic        GntA, GntB, RValidA, RValidB, MemRead, MemWrite;
    logic [31:0] RData, MemAddress, MemWriteData, MemReadData;

    always #5 Clk = ~Clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqA(ReqA), .WeA(WeA), .AddrA(AddrA), .WDataA(WDataA),
        .ReqB(ReqB), .WeB(WeB), .AddrB(AddrB), .WDataB(WDataB),
        .GntA(GntA), .GntB(GntB), .RValidA(RValidA), .RValidB(RValidB),
        .RData(RData), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
    );

    // Data memory: 16 words, read data registered on the edge ending a MemRead cycle.
    logic [31:0] mem [16];
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;
    assign MemReadData = mem_rdata;

    always @(posedge Clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem_rdata <= 32'h0;
            mem_ready <= 1'b1;
        end else begin
            if (MemWrite) mem[MemAddress[5:2]] <= MemWriteData;
            if (MemRead)  mem_rdata <= mem[MemAddress[5:2]];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: arbiter is free from edge free_edge on; a read answers one cycle after its grant.
    logic [31:0] ref_mem [16];
    int          free_edge = 0;
    int          resp_edge = -1;
    logic        resp_port;
    logic [31:0] resp_data;
    logic        rr_last = 1'b1;
    logic        e_gnt_a, e_gnt_b, e_rv_a, e_rv_b, e_mr, e_mw, e_access, e_rst;
    logic [31:0] e_addr, e_wdata, e_rdata;

    task automatic step();
        logic        w, we;
        logic [31:0] a, d;
        {e_gnt_a, e_gnt_b, e_rv_a, e_rv_b, e_mr, e_mw, e_access} = '0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
        e_rst = !Rst_n;
        if (!Rst_n) begin
            free_edge = cyc + 1;
            resp_edge = -1;
            rr_last   = 1'b1;
        end else begin
            if (cyc == resp_edge) begin
                e_rv_a  = !resp_port;
                e_rv_b  = resp_port;
                e_rdata = resp_data;
            end
            if (cyc >= free_edge && (ReqA || ReqB)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                w = (ReqA && ReqB) ? !rr_last : !ReqA;
`else
                w = !ReqA;
`endif
                rr_last = w;
                we = w ? WeB : WeA;
                a  = w ? AddrB : AddrA;
                d  = w ? WDataB : WDataA;
                e_access = 1'b1;
                e_gnt_a  = !w;
                e_gnt_b  = w;
                e_mw     = we;
                e_mr     = !we;
                e_addr   = a;
                e_wdata  = d;
                if (we) begin
                    ref_mem[a[5:2]] = d;
                    free_edge = cyc + 2;
                end else begin
                    resp_edge = cyc + 1;
                    resp_port = w;
                    resp_data = ref_mem[a[5:2]];
                    free_edge = cyc + 3;
                end
                $display("txn cycle %0d port %s %s addr 0x%08h data 0x%08h", cyc,
                         w ? "B" : "A", we ? "WR" : "RD", a, we ? d : ref_mem[a[5:2]]);
            end
        end
        @(posedge Clk);
        #1;
        chk("gnt_a", GntA, e_gnt_a);
        chk("gnt_b", GntB, e_gnt_b);
        chk("rvalid_a", RValidA, e_rv_a);
        chk("rvalid_b", RValidB, e_rv_b);
        chk("mem_read", MemRead, e_mr);
        chk("mem_write", MemWrite, e_mw);
        if (e_access) begin
            chk("mem_addr", MemAddress, e_addr);
            chk("mem_wdata", MemWriteData, e_wdata);
        end
        if (e_rv_a || e_rv_b) chk("rdata", RData, e_rdata);
        if (e_rst) begin
            chk("rst_addr", MemAddress, 32'h0);
            chk("rst_wdata", MemWriteData, 32'h0);
            chk("rst_rdata", RData, 32'h0);
        end
        cyc++;
    endtask

    // Protocol checker, sampled mid-cycle.
    logic chk_on = 1'b0;
    always @(negedge Clk) begin
        if (chk_on) begin
            chk("proto_rd_wr", {31'b0, MemRead & MemWrite}, 32'h0);
            chk("proto_gnt", {31'b0, GntA & GntB}, 32'h0);
            chk("proto_rvalid", {31'b0, RValidA & RValidB}, 32'h0);
        end
    end

    task automatic new_req(input logic port);
        logic [31:0] a;
        a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
        if (port) begin
            ReqB = 1'b1; WeB = 1'($urandom_range(0, 1)); AddrB = a; WDataB = $urandom;
        end else begin
            ReqA = 1'b1; WeA = 1'($urandom_range(0, 1)); AddrA = a; WDataA = $urandom;
        end
    endtask

    logic [3:0] seq;
    int         ng, last_g;
    logic       got;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        Rst_n = 1'b0;
        {ReqA, WeA, ReqB, WeB} = '0;
        {AddrA, WDataA, AddrB, WDataB} = '0;

        // Reset state
        step(); step();
        chk_on = 1'b1;
        chk("reset_ctrl", {26'b0, GntA, GntB, RValidA, RValidB, MemRead, MemWrite}, 32'h0);
        chk("reset_addr", MemAddress, 32'h0);
        Rst_n = 1'b1;
        step();

        // Single write from A
        ReqA = 1'b1; WeA = 1'b1; AddrA = 32'h10; WDataA = 32'hDEADBEEF;
        step();
        chk("wr_gnt_a", GntA, 1);
        chk("wr_mem_write", MemWrite, 1);
        chk("wr_addr", MemAddress, 32'h10);
        chk("wr_data", MemWriteData, 32'hDEADBEEF);
        ReqA = 1'b0;
        step();
        chk("wr_idle_after", {30'b0, GntA, MemWrite}, 32'h0);

        // Single read from B of the same word
        ReqB = 1'b1; WeB = 1'b0; AddrB = 32'h10;
        step();
        chk("rd_gnt_b", GntB, 1);
        chk("rd_mem_read", MemRead, 1);
        chk("rd_rvalid_a_early", RValidA, 0);
        ReqB = 1'b0;
        step();
        chk("rd_rvalid_b", RValidB, 1);
        chk("rd_rdata", RData, 32'hDEADBEEF);
        chk("rd_rvalid_a", RValidA, 0);
        step();

        // Both ports read continuously: grant order shows the policy
        Rst_n = 1'b0; step(); Rst_n = 1'b1;
        ReqA = 1'b1; WeA = 1'b0; AddrA = 32'h0;
        ReqB = 1'b1; WeB = 1'b0; AddrB = 32'h4;
        seq = '0; ng = 0;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            step();
            if (GntA || GntB) begin seq[ng] = GntB; ng++; end
        end
        chk("arb_grants", ng, 4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("arb_order", {28'b0, seq}, 32'hA);
`else
        chk("arb_order", {28'b0, seq}, 32'h0);
`endif
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (GntA) got = 1'b1;
        end
        chk("arb_a_regrant", got, 1);
        ReqA = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (GntB) got = 1'b1;
        end
        chk("arb_b_after_a_drop", got, 1);
        ReqB = 1'b0;
        step(); step(); step();

        // Reset in the ACCESS cycle of a read abandons it
        ReqA = 1'b1; WeA = 1'b0; AddrA = 32'h10;
        step();
        chk("rr_gnt_a", GntA, 1);
        Rst_n = 1'b0; ReqA = 1'b0;
        step();
        chk("rr_outs_zero", {26'b0, GntA, GntB, RValidA, RValidB, MemRead, MemWrite}, 32'h0);
        chk("rr_addr_zero", MemAddress, 32'h0);
        Rst_n = 1'b1;
        step(); step();
        ReqA = 1'b1;
        step();
        chk("rr_new_gnt_a", GntA, 1);
        ReqA = 1'b0;
        step();
        chk("rr_new_rvalid", RValidA, 1);
        chk("rr_new_rdata", RData, 32'hDEADBEEF);
        step();

        // Back-to-back writes from A
        last_g = -1;
        for (int k = 0; k < 3; k++) begin
            ReqA = 1'b1; WeA = 1'b1; AddrA = 32'(k * 4); WDataA = 32'hA5A50000 + 32'(k);
            got = 1'b0;
            for (int i = 0; i < 6 && !got; i++) begin
                step();
                if (GntA) got = 1'b1;
            end
            chk("b2b_gnt", got, 1);
            if (last_g >= 0) chk("b2b_gap", cyc - last_g, 2);
            last_g = cyc;
        end
        ReqA = 1'b0;
        step();
        chk("b2b_mem0", mem[0], 32'hA5A50000);
        chk("b2b_mem1", mem[1], 32'hA5A50001);
        chk("b2b_mem2", mem[2], 32'hA5A50002);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            Rst_n = ($urandom_range(0, 299) != 0);
            if (!Rst_n) begin ReqA = 1'b0; ReqB = 1'b0; end
            step();
            if (e_gnt_a) ReqA = 1'b0;
            if (e_gnt_b) ReqB = 1'b0;
            if (Rst_n && !ReqA && $urandom_range(0, 2) != 0) new_req(1'b0);
            if (Rst_n && !ReqB && $urandom_range(0, 2) != 0) new_req(1'b1);
        end
        ReqA = 1'b0; ReqB = 1'b0; Rst_n = 1'b1;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, sets the data width of both requester ports and the memory port.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Rst_n  input  1  synchronous, active-low reset, sampled on posedge Clk.
REQ-005 ReqA / ReqB  input  1  access request from requester A (CPU load/store) or B (loader/debug).
REQ-006 WeA / WeB  input  1  1 = write, 0 = read; held stable with Req.
REQ-007 AddrA / AddrB  input  ADDR_W  byte address; held stable with Req.
REQ-008 WDataA / WDataB  input  DATA_W  write data; held stable with Req.
REQ-009 GntA / GntB  output  1  one-cycle pulse when that port's request is accepted.
REQ-010 RValidA / RValidB  output  1  one-cycle pulse when RData holds that port's read result.
REQ-011 RData  output  DATA_W  read data shared by both ports; qualified by RValidA/RValidB.
REQ-012 MemAddress  output  ADDR_W  address to data memory.
REQ-013 MemWriteData  output  DATA_W  write data to data memory.
REQ-014 MemRead / MemWrite  output  1  data memory read/write enables; never both high.
REQ-015 MemReadData  input  DATA_W  data memory output; registered by the memory on the posedge ending a MemRead cycle.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP.
REQ-017 IDLE: if ReqA or ReqB is high at posedge, latch the winner's We/Addr/WData into the command register, record the winner, go to ACCESS; otherwise remain in IDLE.
REQ-018 ACCESS lasts exactly one cycle: drive MemAddress/MemWriteData from the command register, MemWrite=We, MemRead=!We, pulse the winner's Gnt.
REQ-019 ACCESS -> IDLE for a write; ACCESS -> RESP for a read.
REQ-020 RESP lasts exactly one cycle: RData=MemReadData, pulse the winner's RValid, MemRead=MemWrite=0, then go to IDLE.
REQ-021 Latency from request sampled to Gnt: 1 cycle. Read data is valid 2 cycles after sampling. Throughput: one write per 2 cycles, one read per 3 cycles.
REQ-022 Outside ACCESS, MemRead=MemWrite=0. Outside their defined cycles, GntA/GntB/RValidA/RValidB=0.
REQ-023 Requesters keep Req and its fields stable until Gnt, then deassert Req or present a new request on the following cycle.
REQ-024 A request is never dropped or reordered. A losing request stays pending and is arbitrated at the next IDLE.
REQ-025 At most one of GntA/GntB, and at most one of RValidA/RValidB, is high in any cycle.

Reset
REQ-026 While Rst_n=0 at posedge: state=IDLE; all outputs are 0; the command register is cleared; the round-robin pointer (if present) prefers A.
REQ-027 Reset during ACCESS or RESP abandons the transaction with no Gnt or RValid afterwards. A write in its ACCESS cycle may or may not complete.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN defined:
- When both ports request in IDLE, the port not granted last wins.
- A pointer updates on every grant.
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN undefined:
- Fixed priority: A always wins over B.
- No pointer register exists.

Structure
REQ-030 Package mem_arb_pkg holds the state enum (IDLE/ACCESS/RESP), the port-id constants (PORT_A=0, PORT_B=1) and default widths (32).
REQ-031 The winner selection is one sub-module, mem_arb_pick, which is combinational apart from the optional pointer. Everything else lives in mem_arbiter.

Verification
REQ-032 Single write: ReqA=1, WeA=1, AddrA=0x10, WDataA=0xDEADBEEF -> next cycle GntA=1, MemWrite=1, MemAddress=0x10, MemWriteData=0xDEADBEEF; IDLE the cycle after.
REQ-033 Single read after REQ-032: ReqB=1, WeB=0, AddrB=0x10 -> GntB at +1, MemRead=1 at +1, RValidB=1 with RData=0xDEADBEEF at +2, RValidA=0 throughout.
REQ-034 Simultaneous reads, A at 0x0 and B at 0x4, held until granted:
- With MEM_ARB_ROUND_ROBIN_EN after reset: order A then B.
- Repeated for 4 rounds: grants alternate A,B,A,B.
- Without the macro: A always wins while ReqA is held, and B is granted only after A drops.
REQ-035 Reset mid-read: assert Rst_n=0 in the ACCESS cycle of a read -> no RValid ever pulses; all outputs are 0 the cycle after reset; a new ReqA then completes normally.
REQ-036 Back-to-back writes from A to 0x0, 0x4, 0x8 -> GntA pulses every 2 cycles; MemRead stays 0; memory holds all three values.
REQ-037 Protocol checker on all tests: MemRead&MemWrite never high together; GntA&GntB never high together; RValidA&RValidB never high together; every Gnt for a read is followed by exactly one RValid.
